// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM states and the
// bundle of pipeline-register enable/flush bits.
package pipe_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef struct packed {
    logic en_pc;
    logic en_ifid;
    logic flush_ifid;
    logic en_idex;
    logic flush_idex;
    logic en_exmem;
  } ctrl_t;

  // Branch / load-use / free-run decisions, used both in RUN and on the
  // memory-ack cycle out of MEMWAIT.
  function automatic ctrl_t run_ctrl(input logic branch_taken, input logic load_use);
    ctrl_t c;
    c = '0;
    if (branch_taken) begin
      c = '{en_pc: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b1,
            en_idex: 1'b1, flush_idex: 1'b1, en_exmem: 1'b1};
    end else if (load_use) begin
      c = '{en_pc: 1'b0, en_ifid: 1'b0, flush_ifid: 1'b0,
            en_idex: 1'b1, flush_idex: 1'b1, en_exmem: 1'b1};
    end else begin
      c = '{en_pc: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b0,
            en_idex: 1'b1, flush_idex: 1'b0, en_exmem: 1'b1};
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and pipe_ctrl (slave).
// Memory handshake: the EX load/store flags act as a request held until the
// cycle in which mem_ack is high; that cycle completes the access.
interface pipe_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ra_id;
  logic [REG_W-1:0] rb_id;
  logic             uses_ra_id;
  logic             uses_rb_id;
  logic [REG_W-1:0] regwrite_adr_ex;
  logic             regwrite_ex;
  logic             main_mem_read_ex;
  logic             main_mem_write_ex;
  logic             branch_taken_ex;
  logic             is_halt_ex;
  logic             mem_ack;
  logic             resume;

  logic             en_pc;
  logic             en_ifid;
  logic             flush_ifid;
  logic             en_idex;
  logic             flush_idex;
  logic             en_exmem;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  state_t           dbg_state;

  modport master (
    output ra_id, rb_id, uses_ra_id, uses_rb_id, regwrite_adr_ex, regwrite_ex,
           main_mem_read_ex, main_mem_write_ex, branch_taken_ex, is_halt_ex,
           mem_ack, resume,
    input  en_pc, en_ifid, flush_ifid, en_idex, flush_idex, en_exmem, halted,
           mem_err, stall_cycles, flush_count, dbg_state
  );

  modport slave (
    input  ra_id, rb_id, uses_ra_id, uses_rb_id, regwrite_adr_ex, regwrite_ex,
           main_mem_read_ex, main_mem_write_ex, branch_taken_ex, is_halt_ex,
           mem_ack, resume,
    output en_pc, en_ifid, flush_ifid, en_idex, flush_idex, en_exmem, halted,
           mem_err, stall_cycles, flush_count, dbg_state
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction currently in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] ra_id,
  input  logic [REG_W-1:0] rb_id,
  input  logic             uses_ra_id,
  input  logic             uses_rb_id,
  input  logic [REG_W-1:0] regwrite_adr_ex,
  input  logic             regwrite_ex,
  input  logic             main_mem_read_ex,
  output logic             load_use
);
  assign load_use = main_mem_read_ex & regwrite_ex &
                    ((uses_ra_id & (ra_id == regwrite_adr_ex)) |
                     (uses_rb_id & (rb_id == regwrite_adr_ex)));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller owning the RUN/MEMWAIT/HALT state.
// Optional saturating performance counters under `PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic        clk,
  input logic        reset,
  pipe_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  ctrl_t             ctrl;
  logic              halt_raw;
  logic              load_use;
  logic              mem_op;

  assign mem_op = bus.main_mem_read_ex | bus.main_mem_write_ex;

  hazard_detect u_hazard (
    .ra_id            (bus.ra_id),
    .rb_id            (bus.rb_id),
    .uses_ra_id       (bus.uses_ra_id),
    .uses_rb_id       (bus.uses_rb_id),
    .regwrite_adr_ex  (bus.regwrite_adr_ex),
    .regwrite_ex      (bus.regwrite_ex),
    .main_mem_read_ex (bus.main_mem_read_ex),
    .load_use         (load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    ctrl     = '0;
    halt_raw = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_op && !bus.mem_ack) begin
          state_d = ST_MEMWAIT;
          wait_d  = WAIT_W'(1);
        end else if (bus.is_halt_ex) begin
          // Let older instructions in EX/MEM drain while HLT stays in EX.
          ctrl.en_exmem = 1'b1;
          state_d       = ST_HALT;
        end else begin
          ctrl = run_ctrl(bus.branch_taken_ex, load_use);
        end
      end
      ST_MEMWAIT: begin
        if (bus.mem_ack) begin
          ctrl    = run_ctrl(bus.branch_taken_ex, load_use);
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        halt_raw = 1'b1;
        // Bubble out the HLT in EX; PC and IF/ID already hold the next one.
        if (bus.resume && !err_q) begin
          ctrl.en_idex    = 1'b1;
          ctrl.flush_idex = 1'b1;
          state_d         = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.en_pc      = reset & ctrl.en_pc;
  assign bus.en_ifid    = reset & ctrl.en_ifid;
  assign bus.flush_ifid = reset & ctrl.flush_ifid;
  assign bus.en_idex    = reset & ctrl.en_idex;
  assign bus.flush_idex = reset & ctrl.flush_idex;
  assign bus.en_exmem   = reset & ctrl.en_exmem;
  assign bus.halted     = reset & halt_raw;
  assign bus.mem_err    = err_q;
  assign bus.dbg_state  = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!bus.en_pc && (stall_q != '1))     stall_q <= stall_q + CNT_W'(1);
      if (bus.flush_idex && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-scenario tasks push expected output
// vectors into a queue and compare them against sampled DUT outputs.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int W           = 10;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctrl bit order: en_pc en_ifid flush_ifid en_idex flush_idex en_exmem
  localparam logic [5:0] C_STALL = 6'b000000;
  localparam logic [5:0] C_NORM  = 6'b110101;
  localparam logic [5:0] C_LU    = 6'b000111;
  localparam logic [5:0] C_BR    = 6'b111111;
  localparam logic [5:0] C_HLT   = 6'b000001;
  localparam logic [5:0] C_RES   = 6'b000110;
  localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_HALT = 2'd2;

  logic clk;
  logic reset;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, want;
  int n_chk  = 0;
  int n_fail = 0;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    bus.ra_id = '0; bus.rb_id = '0; bus.uses_ra_id = 1'b0; bus.uses_rb_id = 1'b0;
    bus.regwrite_adr_ex = '0; bus.regwrite_ex = 1'b0;
    bus.main_mem_read_ex = 1'b0; bus.main_mem_write_ex = 1'b0;
    bus.branch_taken_ex = 1'b0; bus.is_halt_ex = 1'b0;
    bus.mem_ack = 1'b0; bus.resume = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic [5:0] c,
                                      input logic h, input logic e);
    return {st, c, h, e};
  endfunction

  function automatic logic [W-1:0] obs();
    return {bus.dbg_state, bus.en_pc, bus.en_ifid, bus.flush_ifid, bus.en_idex,
            bus.flush_idex, bus.en_exmem, bus.halted, bus.mem_err};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_in();
    bus.branch_taken_ex = 1'b1;
    bus.main_mem_write_ex = 1'b1;
    exp_q.push_back(mk(S_RUN, C_STALL, 1'b0, 1'b0));
    #3;
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL reset_outputs got=%b want=%b", got, want); end
    n_chk++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
      n_fail++; $display("FAIL reset_counters got=%0d/%0d want=0/0", bus.stall_cycles, bus.flush_count);
    end
    next_cycle();
    reset = 1'b1;
    clear_in();
    exp_q.push_back(mk(S_RUN, C_NORM, 1'b0, 1'b0));
    #3;
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL reset_release got=%b want=%b", got, want); end
  endtask

  task automatic test_load_use();
    logic [5:0] tab [6] = '{C_LU, C_NORM, C_LU, C_NORM, C_NORM, C_NORM};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      clear_in();
      bus.regwrite_adr_ex = 3'd1; bus.mem_ack = 1'b1; bus.regwrite_ex = 1'b1;
      case (i)
        0: begin bus.main_mem_read_ex = 1'b1; bus.ra_id = 3'd1; bus.uses_ra_id = 1'b1; end
        1: begin bus.ra_id = 3'd1; bus.uses_ra_id = 1'b1; end
        2: begin bus.main_mem_read_ex = 1'b1; bus.rb_id = 3'd1; bus.uses_rb_id = 1'b1; bus.ra_id = 3'd4; bus.uses_ra_id = 1'b1; end
        3: begin bus.main_mem_read_ex = 1'b1; bus.ra_id = 3'd1; bus.uses_ra_id = 1'b0; end
        4: begin bus.main_mem_read_ex = 1'b1; bus.ra_id = 3'd1; bus.uses_ra_id = 1'b1; bus.regwrite_ex = 1'b0; end
        default: begin bus.main_mem_read_ex = 1'b1; bus.rb_id = 3'd2; bus.uses_rb_id = 1'b1; end
      endcase
      exp_q.push_back(mk(S_RUN, tab[i], 1'b0, 1'b0));
      #3;
      got = obs(); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_hazard_random();
    logic lu;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      clear_in();
      bus.ra_id = 3'($urandom_range(0, 7));
      bus.rb_id = 3'($urandom_range(0, 7));
      bus.regwrite_adr_ex = 3'($urandom_range(0, 7));
      bus.uses_ra_id = 1'($urandom_range(0, 1));
      bus.uses_rb_id = 1'($urandom_range(0, 1));
      bus.regwrite_ex = 1'($urandom_range(0, 1));
      bus.main_mem_read_ex = 1'b1;
      bus.mem_ack = 1'b1;
      lu = bus.regwrite_ex &
           ((bus.uses_ra_id && bus.ra_id == bus.regwrite_adr_ex) ||
            (bus.uses_rb_id && bus.rb_id == bus.regwrite_adr_ex));
      exp_q.push_back(mk(S_RUN, lu ? C_LU : C_NORM, 1'b0, 1'b0));
      #3;
      got = obs(); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL hazard_rand[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_branch();
    next_cycle();
    clear_in();
    bus.branch_taken_ex = 1'b1;
    bus.main_mem_read_ex = 1'b1; bus.mem_ack = 1'b1; bus.regwrite_ex = 1'b1;
    bus.regwrite_adr_ex = 3'd3; bus.ra_id = 3'd3; bus.uses_ra_id = 1'b1;
    exp_q.push_back(mk(S_RUN, C_BR, 1'b0, 1'b0));
    #3;
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL branch_over_load_use got=%b want=%b", got, want); end
  endtask

  task automatic test_mem_wait();
    logic [W-1:0] tab [6];
    tab[0] = mk(S_RUN, C_STALL, 1'b0, 1'b0);
    tab[1] = mk(S_MW,  C_STALL, 1'b0, 1'b0);
    tab[2] = mk(S_MW,  C_STALL, 1'b0, 1'b0);
    tab[3] = mk(S_MW,  C_NORM,  1'b0, 1'b0);
    tab[4] = mk(S_MW,  C_BR,    1'b0, 1'b0);
    tab[5] = mk(S_RUN, C_NORM,  1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      clear_in();
      // store with 3 wait cycles, then a load with 1 wait acked alongside a branch
      bus.main_mem_write_ex = (i < 4);
      bus.main_mem_read_ex  = (i == 4);
      bus.mem_ack = (i == 3) || (i == 4 && exp_q.size() == 0 && 1'b0);
      if (i == 4) begin bus.mem_ack = 1'b0; end
      exp_q.push_back(tab[i]);
      if (i == 4) begin
        // first cycle of the load stalls in RUN, ack + branch arrives next cycle
        want = exp_q.pop_front();
        #3;
        got = obs(); n_chk++;
        if (got !== mk(S_RUN, C_STALL, 1'b0, 1'b0)) begin
          n_fail++; $display("FAIL mem_wait_load_req got=%b want=%b", got, mk(S_RUN, C_STALL, 1'b0, 1'b0));
        end
        exp_q.push_back(want);
        next_cycle();
        clear_in();
        bus.main_mem_read_ex = 1'b1; bus.mem_ack = 1'b1; bus.branch_taken_ex = 1'b1;
      end
      #3;
      got = obs(); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL mem_wait[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_reset_memwait();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      clear_in();
      bus.main_mem_write_ex = (i < 3);
      reset = (i != 2);
      exp_q.push_back(i == 0 ? mk(S_RUN, C_STALL, 1'b0, 1'b0) :
                      i == 1 ? mk(S_MW,  C_STALL, 1'b0, 1'b0) :
                      i == 2 ? mk(S_RUN, C_STALL, 1'b0, 1'b0) :
                               mk(S_RUN, C_NORM,  1'b0, 1'b0));
      #3;
      got = obs(); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL reset_memwait[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_timeout();
    // cycle 0 RUN request, 1..4 MEMWAIT counting to MEM_TIMEOUT, then HALT with error
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      clear_in();
      bus.main_mem_read_ex = (i < 6);
      bus.resume = (i >= 6 && i < 8);
      reset = (i != 8);
      if (i == 0)      exp_q.push_back(mk(S_RUN,  C_STALL, 1'b0, 1'b0));
      else if (i <= 4) exp_q.push_back(mk(S_MW,   C_STALL, 1'b0, 1'b0));
      else if (i <= 7) exp_q.push_back(mk(S_HALT, C_STALL, 1'b1, 1'b1));
      else if (i == 8) exp_q.push_back(mk(S_RUN,  C_STALL, 1'b0, 1'b0));
      else             exp_q.push_back(mk(S_RUN,  C_NORM,  1'b0, 1'b0));
      #3;
      got = obs(); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL timeout[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_halt();
    logic [W-1:0] tab [5];
    tab[0] = mk(S_RUN,  C_HLT,   1'b0, 1'b0);
    tab[1] = mk(S_HALT, C_STALL, 1'b1, 1'b0);
    tab[2] = mk(S_HALT, C_STALL, 1'b1, 1'b0);
    tab[3] = mk(S_HALT, C_RES,   1'b1, 1'b0);
    tab[4] = mk(S_RUN,  C_NORM,  1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      clear_in();
      bus.is_halt_ex = (i < 4);
      bus.branch_taken_ex = (i == 0);
      bus.resume = (i >= 3);
      exp_q.push_back(tab[i]);
      #3;
      got = obs(); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL halt[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_perf();
    next_cycle();
    clear_in();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    bus.main_mem_read_ex = 1'b1; bus.mem_ack = 1'b1; bus.regwrite_ex = 1'b1;
    bus.regwrite_adr_ex = 3'd5; bus.rb_id = 3'd5; bus.uses_rb_id = 1'b1;
    next_cycle();
    clear_in();
    bus.is_halt_ex = 1'b1;
    #3;
    n_chk++;
    if (bus.stall_cycles !== (PERF ? 4'd1 : 4'd0) || bus.flush_count !== (PERF ? 4'd1 : 4'd0)) begin
      n_fail++; $display("FAIL perf_first got=%0d/%0d want=%0d/%0d", bus.stall_cycles,
                         bus.flush_count, PERF ? 1 : 0, PERF ? 1 : 0);
    end
    for (int i = 0; i < 20; i++) next_cycle();
    #3;
    n_chk++;
    if (bus.halted !== 1'b1 || bus.stall_cycles !== (PERF ? 4'd15 : 4'd0) ||
        bus.flush_count !== (PERF ? 4'd1 : 4'd0)) begin
      n_fail++; $display("FAIL perf_saturate got=h%0b s%0d f%0d want=h1 s%0d f%0d", bus.halted,
                         bus.stall_cycles, bus.flush_count, PERF ? 15 : 0, PERF ? 1 : 0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    clear_in();
    test_reset();
    test_load_use();
    test_hazard_random();
    test_branch();
    test_mem_wait();
    test_reset_memwait();
    test_timeout();
    test_halt();
    test_perf();
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
